// File: rtl/iic_pkg.sv
// iic_pkg: shared types and widths for the iic_master transaction arbiter
package iic_pkg;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ = 1'b1;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, RESP, ABORT} state_t;
endpackage

// File: rtl/iic_rr_pick.sv
// iic_rr_pick: combinational round-robin picker searching upward from last+1 with wrap
//   req  : request vector        last : index granted previously
//   gnt  : one-hot winner (0 when no request)   idx : binary winner index
module iic_rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   last,
  output logic [N-1:0] gnt,
  output logic [2:0]   idx
);
  logic [N-1:0] hi;
  logic [N-1:0] sel;
  always_comb begin
    for (int i = 0; i < N; i++) hi[i] = req[i] && (3'(i) > last);
    sel = (|hi) ? hi : req;
    gnt = sel & -sel;
    idx = '0;
    for (int i = 0; i < N; i++) idx = gnt[i] ? 3'(i) : idx;
  end
endmodule

// File: rtl/iic_txn_arbiter.sv
// iic_txn_arbiter: round-robin sequencer sharing one iic_master between NUM_REQ requesters
//   req_*  : per-requester command in, req_ready one-hot accept pulse
//   rsp_*  : one-hot completion pulse to the owner with read byte and timeout flag
//   m_*    : iic_master control; m_abort is ORed into the master reset
//   owner  : current or last granted requester
module iic_txn_arbiter
  import iic_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 4096,
  parameter int ABORT_CYC   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_rw,
  input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
  input  logic [DATA_W*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_timeout,
  output logic                      m_start,
  output logic                      m_rw,
  output logic [ADDR_W-1:0]         m_addr,
  output logic [DATA_W-1:0]         m_wdata,
  input  logic [DATA_W-1:0]         m_rdata,
  input  logic                      m_busy,
  input  logic                      m_done,
  output logic                      m_abort,
  output logic [2:0]                owner
);
  localparam int WW = $clog2(TIMEOUT_CYC);
  state_t state, nxt;
  logic [NUM_REQ-1:0] gnt;
  logic [2:0] pick, last, owner_q;
  logic [WW-1:0] wd;
  logic rw_q, to_q, sel_rw;
  logic [ADDR_W-1:0] addr_q, sel_addr;
  logic [DATA_W-1:0] wdata_q, rdata_q, sel_wdata;
  logic expire, abort_end;
  iic_rr_pick #(.N(NUM_REQ)) u_pick (
    .req (req_valid),
    .last(last),
    .gnt (gnt),
    .idx (pick)
  );
  // wd holds the count of WAIT_DONE cycles already completed, so the
  // incremented value reaching TIMEOUT_CYC-1 is this compare against -2
  assign expire = wd == WW'(TIMEOUT_CYC - 2);
  assign abort_end = wd == WW'(ABORT_CYC - 1);
  always_comb begin
    sel_rw = |(req_rw & gnt);
    sel_addr = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_addr = sel_addr | (gnt[i] ? req_addr[ADDR_W*i +: ADDR_W] : '0);
      sel_wdata = sel_wdata | (gnt[i] ? req_wdata[DATA_W*i +: DATA_W] : '0);
    end
  end
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:      nxt = (|req_valid) ? ISSUE : IDLE;
      ISSUE:     nxt = WAIT_DONE;
      WAIT_DONE: nxt = m_done ? RESP : expire ? ABORT : WAIT_DONE;
      ABORT:     nxt = abort_end ? RESP : ABORT;
      default:   nxt = IDLE;
    endcase
  end
  always_comb begin
    req_ready = (state == IDLE) ? gnt : '0;
    m_start = state == ISSUE;
    m_abort = state == ABORT;
    rsp_valid = (state == RESP) ? {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q : '0;
    rsp_timeout = (state == RESP) && to_q;
    rsp_rdata = rdata_q;
    m_rw = rw_q;
    m_addr = addr_q;
    m_wdata = wdata_q;
    owner = owner_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rw_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      to_q <= 1'b0;
      owner_q <= '0;
      last <= 3'(NUM_REQ - 1);
      wd <= '0;
    end else begin
      if (state == IDLE && |req_valid) begin
        rw_q <= sel_rw;
        addr_q <= sel_addr;
        wdata_q <= sel_wdata;
        owner_q <= pick;
        last <= pick;
      end
      // one counter serves as watchdog in WAIT_DONE and as hold timer in ABORT
      wd <= ((state == WAIT_DONE || state == ABORT) && nxt == state) ? wd + WW'(1) : '0;
      if (state == WAIT_DONE && m_done) begin
        rdata_q <= m_rdata;
        to_q <= 1'b0;
      end else if (state == WAIT_DONE && expire) begin
        rdata_q <= '0;
        to_q <= 1'b1;
      end
    end
  end
  a_busy_idle: assert property (@(posedge clk) disable iff (rst) !(m_busy && state == IDLE));
endmodule

// File: tb/tb_iic_txn_arbiter.sv
// tb_iic_txn_arbiter: scoreboard bench with a round-robin reference model and an iic_master model
module tb_iic_txn_arbiter;
  import iic_pkg::*;
  localparam int N = 4;
  localparam int TO = 64;
  localparam int AB = 2;
  typedef struct packed {
    logic [2:0] idx;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wd;
    logic [7:0] rd;
    logic       to;
  } txn_t;
  logic clk = 0, rst = 1;
  logic [N-1:0] req_valid = '0, req_rw = '0, req_ready, rsp_valid;
  logic [7*N-1:0] req_addr = '0;
  logic [8*N-1:0] req_wdata = '0;
  logic [7:0] rsp_rdata, m_wdata, m_rdata = '0;
  logic rsp_timeout, m_start, m_rw, m_abort, m_busy = 0, m_done = 0;
  logic [6:0] m_addr;
  logic [2:0] owner;
  iic_txn_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TO), .ABORT_CYC(AB)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_timeout(rsp_timeout), .m_start(m_start), .m_rw(m_rw), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_busy(m_busy), .m_done(m_done),
    .m_abort(m_abort), .owner(owner)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  txn_t gq[$], sq[$], rq[$];
  logic [7:0] ref_mem[128], mst_mem[128];
  logic c_rw[N][4];
  logic [6:0] c_addr[N][4];
  logic [7:0] c_wd[N][4];
  int cnt[N], pos[N];
  int m_last = N - 1;
  logic [N-1:0] rdy_seen = '0, glitch = '0;
  logic hang = 0;
  int force_delay = 0;
  logic mrw;
  logic [6:0] maddr;
  logic [7:0] mwd;
  int mcnt = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  // monitor: checks every DUT output event against the scoreboard queues
  int mc = 0, rdy_cyc = 0, last_start = 0, done_cyc = 0, ab_len = 0;
  logic have_start = 0, ab_prev = 0;
  always @(negedge clk) begin
    txn_t t;
    mc++;
    if (rst) begin
      have_start = 0;
      ab_len = 0;
      ab_prev = 0;
    end else begin
      if (req_ready != 0) begin
        rdy_seen = rdy_seen | req_ready;
        rdy_cyc = mc;
        chk("grant", 32'(req_ready), gq.size() != 0 ? 32'(1) << gq[0].idx : 32'(0));
        if (gq.size() != 0) void'(gq.pop_front());
      end
      if (m_start) begin
        chk("start_expected", 32'(sq.size() != 0), 1);
        if (sq.size() != 0) begin
          t = sq.pop_front();
          chk("start_fields", {16'(0), m_rw, m_addr, m_wdata}, {16'(0), t.rw, t.addr, t.wd});
        end
        chk("start_latency", 32'(mc - rdy_cyc), 1);
        if (have_start) chk("start_gap", 32'(mc - last_start >= 3), 1);
        last_start = mc;
        have_start = 1;
      end
      if (m_done) done_cyc = mc;
      if (m_abort) begin
        if (!ab_prev) begin
          chk("abort_expected", 32'(hang), 1);
          chk("abort_offset", 32'(mc - last_start), TO);
        end
        ab_len++;
      end else if (ab_prev) begin
        chk("abort_len", 32'(ab_len), AB);
        ab_len = 0;
      end
      ab_prev = m_abort;
      if (rsp_valid != 0) begin
        if (rq.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 0);
        else begin
          t = rq.pop_front();
          chk("rsp_who", 32'(rsp_valid), 32'(1) << t.idx);
          chk("rsp_owner", 32'(owner), 32'(t.idx));
          chk("rsp_timeout", 32'(rsp_timeout), 32'(t.to));
          if (t.to || t.rw) chk("rsp_rdata", 32'(rsp_rdata), 32'(t.rd));
          if (!t.to) chk("rsp_latency", 32'(mc - done_cyc), 1);
        end
      end
    end
  end
  // iic_master behaviour: done D cycles after start, read from its own memory
  task automatic master_step();
    if (m_abort) begin
      m_busy = 0;
      m_done = 0;
      mcnt = 0;
    end else begin
      m_done = 0;
      if (mcnt > 0) begin
        mcnt--;
        if (mcnt == 0) begin
          m_done = 1;
          m_busy = 0;
          if (mrw == RW_READ) m_rdata = mst_mem[maddr];
          else begin
            mst_mem[maddr] = mwd;
            m_rdata = 8'($urandom);
          end
        end
      end
      if (m_start) begin
        m_busy = 1;
        mrw = m_rw;
        maddr = m_addr;
        mwd = m_wdata;
        mcnt = hang ? 0 : force_delay != 0 ? force_delay : int'($urandom_range(1, 20));
      end
    end
  endtask
  task automatic drive_req();
    for (int i = 0; i < N; i++) begin
      int p;
      if (rdy_seen[i]) pos[i]++;
      p = (pos[i] < cnt[i]) ? pos[i] : 0;
      req_valid[i] = (pos[i] < cnt[i]) | glitch[i];
      req_rw[i] = c_rw[i][p];
      req_addr[7*i +: 7] = c_addr[i][p];
      req_wdata[8*i +: 8] = c_wd[i][p];
    end
    rdy_seen = '0;
    glitch = '0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    master_step();
    drive_req();
  endtask
  // reference model: serve pending commands in round-robin order after m_last
  task automatic plan();
    int k[N];
    int last = m_last;
    for (int i = 0; i < N; i++) begin
      k[i] = 0;
      pos[i] = 0;
    end
    forever begin
      int f = -1;
      txn_t t;
      for (int d = 1; d <= N; d++) if (f < 0 && k[(last + d) % N] < cnt[(last + d) % N]) f = (last + d) % N;
      if (f < 0) break;
      t.idx = 3'(f);
      t.rw = c_rw[f][k[f]];
      t.addr = c_addr[f][k[f]];
      t.wd = c_wd[f][k[f]];
      t.to = hang;
      t.rd = 8'h00;
      if (!hang && t.rw == RW_READ) t.rd = ref_mem[t.addr];
      if (!hang && t.rw == RW_WRITE) ref_mem[t.addr] = t.wd;
      gq.push_back(t);
      sq.push_back(t);
      rq.push_back(t);
      k[f]++;
      last = f;
    end
    m_last = last;
  endtask
  task automatic drain();
    for (int n = 0; n < 3000 && (gq.size() + sq.size() + rq.size()) != 0; n++) tick();
    chk("drain_done", 32'(gq.size() + sq.size() + rq.size()), 0);
    repeat (3) tick();
  endtask
  task automatic clear_cmds();
    for (int i = 0; i < N; i++) cnt[i] = 0;
  endtask
  task automatic set_cmd(input int r, input logic rw, input logic [6:0] a, input logic [7:0] w);
    c_rw[r][cnt[r]] = rw;
    c_addr[r][cnt[r]] = a;
    c_wd[r][cnt[r]] = w;
    cnt[r]++;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end
  initial begin
    for (int i = 0; i < 128; i++) begin
      ref_mem[i] = 8'($urandom);
      mst_mem[i] = ref_mem[i];
    end
    for (int i = 0; i < N; i++) for (int j = 0; j < 4; j++) begin
      c_rw[i][j] = 0;
      c_addr[i][j] = '0;
      c_wd[i][j] = '0;
    end
    clear_cmds();
    repeat (3) tick();
    chk("reset_outs_a", {req_ready, rsp_valid, rsp_rdata, rsp_timeout, m_start, m_abort, owner}, 0);
    chk("reset_outs_b", {m_rw, m_addr, m_wdata}, 0);
    rst = 0;
    tick();
    // single write from requester 0
    clear_cmds();
    set_cmd(0, RW_WRITE, 7'h42, 8'hAA);
    plan();
    drain();
    // read from requester 2 returning 3C
    ref_mem[7'h42] = 8'h3C;
    mst_mem[7'h42] = 8'h3C;
    clear_cmds();
    set_cmd(2, RW_READ, 7'h42, 8'h00);
    plan();
    drain();
    // contention: all four pending, requester 0 holds a second command
    clear_cmds();
    for (int i = 0; i < N; i++) set_cmd(i, 1'($urandom), 7'h40 + 7'($urandom_range(0, 3)), 8'($urandom));
    set_cmd(0, RW_READ, 7'h41, 8'h00);
    plan();
    drain();
    // request withdrawn before grant is dropped
    clear_cmds();
    set_cmd(1, RW_READ, 7'h43, 8'h00);
    force_delay = 30;
    plan();
    repeat (10) tick();
    glitch = 4'b1000;
    tick();
    drain();
    // watchdog expiry
    force_delay = 0;
    hang = 1;
    clear_cmds();
    set_cmd(3, RW_READ, 7'h40, 8'h00);
    plan();
    drain();
    hang = 0;
    // m_done on the expiry cycle wins
    force_delay = TO - 1;
    clear_cmds();
    set_cmd(1, RW_READ, 7'h41, 8'h00);
    plan();
    drain();
    force_delay = 0;
    // reset during WAIT_DONE
    hang = 1;
    clear_cmds();
    set_cmd(1, RW_READ, 7'h41, 8'h00);
    plan();
    for (int n = 0; n < 50 && sq.size() != 0; n++) tick();
    repeat (5) tick();
    rst = 1;
    clear_cmds();
    req_valid = '0;
    m_busy = 0;
    m_done = 0;
    mcnt = 0;
    gq.delete();
    sq.delete();
    rq.delete();
    m_last = N - 1;
    tick();
    rst = 0;
    hang = 0;
    chk("midrst_outs_a", {req_ready, rsp_valid, rsp_rdata, rsp_timeout, m_start, m_abort, owner}, 0);
    chk("midrst_outs_b", {m_rw, m_addr, m_wdata}, 0);
    clear_cmds();
    set_cmd(2, RW_WRITE, 7'h42, 8'h5A);
    set_cmd(0, RW_READ, 7'h42, 8'h00);
    plan();
    drain();
    // randomized batches
    for (int b = 0; b < 12; b++) begin
      logic [N-1:0] msk;
      clear_cmds();
      msk = 4'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) if (msk[i]) repeat ($urandom_range(1, 3))
        set_cmd(i, 1'($urandom), 7'h40 + 7'($urandom_range(0, 3)), 8'($urandom));
      plan();
      drain();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/iic_txn_arbiter.md
Name: iic_txn_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one iic_master between NUM_REQ independent requesters.
- Accepts single-byte read/write commands from each requester and latches the winning command.
- Drives the iic_master start/rw/slave_addr/wdata inputs, waits for done, and routes rdata back to the owner.
- A transaction watchdog aborts hung transfers through a dedicated master-reset request.
- Sits between the system control logic and iic_master; the bus pins stay on iic_master.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYC, 4096, max clk cycles from m_start to m_done before abort.
- ABORT_CYC, 2, cycles m_abort is held high.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester command pending.
- req_rw  in  NUM_REQ  0=write, 1=read.
- req_addr  in  7*NUM_REQ  flattened 7-bit slave addresses; requester i uses bits [7i+6:7i].
- req_wdata  in  8*NUM_REQ  flattened write bytes; requester i uses bits [8i+7:8i].
- req_ready  out  NUM_REQ  one-hot, 1-cycle accept pulse.
- rsp_valid  out  NUM_REQ  one-hot, 1-cycle completion pulse.
- rsp_rdata  out  8  read byte; valid while rsp_valid is asserted.
- rsp_timeout  out  1  qualifies rsp_valid: transaction aborted.
- m_start  out  1  to iic_master start.
- m_rw  out  1  to iic_master rw.
- m_addr  out  7  to iic_master slave_addr.
- m_wdata  out  8  to iic_master wdata.
- m_rdata  in  8  from iic_master rdata.
- m_busy  in  1  from iic_master busy.
- m_done  in  1  from iic_master done.
- m_abort  out  1  ORed externally into the iic_master rst.
- owner  out  3  index of the current or last grant (debug).

Behaviour:
- Reset: all outputs 0; state IDLE; round-robin pointer last = NUM_REQ-1, so requester 0 has first priority. Reset mid-transaction returns to IDLE immediately with no rsp_valid; the system resets iic_master on the same rst.
- IDLE: wait for req_valid != 0.
  - Winner = first set bit searching last+1, last+2, ... with wrap modulo NUM_REQ.
  - On the same cycle: latch rw/addr/wdata, assert req_ready[winner] for 1 cycle, set owner=winner and last=winner.
  - Next state ISSUE.
- ISSUE: m_start=1 for exactly 1 cycle; clear the watchdog counter; go to WAIT_DONE.
- m_rw, m_addr and m_wdata are driven from latched registers, stable from ISSUE until leaving WAIT_DONE. Requesters may change their inputs after req_ready.
- WAIT_DONE: increment the watchdog each cycle.
  - On m_done=1: capture m_rdata (writes capture it too, value don't-care); go to RESP.
  - If the watchdog reaches TIMEOUT_CYC-1 without m_done: go to ABORT.
  - If m_done and expiry occur on the same cycle, m_done wins.
- RESP: rsp_valid[owner]=1 and rsp_timeout=0 for 1 cycle; return to IDLE.
- ABORT: m_abort=1 for ABORT_CYC cycles, then rsp_valid[owner]=1 with rsp_timeout=1 and rsp_rdata=8'h00 for 1 cycle; return to IDLE.
- Latency:
  - req_valid seen in IDLE -> req_ready on the same cycle.
  - m_start asserts the cycle after req_ready.
  - m_done -> rsp_valid one cycle later.
  - Minimum 3 cycles between successive m_start pulses.
- Fairness: a requester holding req_valid continuously is served at most once per NUM_REQ grants while others wait.
- req_valid deasserted before grant: the request is silently dropped, with no response.
- A requester that wins again keeps the same handshake; back-to-back grants to one requester occur only when no other requester is pending.
- Slave NACK is not distinguished; iic_master still raises done, which yields a normal response.
- m_busy is monitored only for the assertion: m_busy high while the FSM is in IDLE flags a simulation error.

Decomposition:
- Package iic_pkg holds:
  - state encoding: IDLE, ISSUE, WAIT_DONE, RESP, ABORT;
  - RW_WRITE/RW_READ constants;
  - the addr/data width constants (7, 8), shared with iic_master.
- One sub-module, iic_rr_pick: combinational round-robin picker.
  - Inputs: NUM_REQ-bit request vector and last index.
  - Outputs: one-hot grant and binary index.
  - Reusable by other shared-bus arbiters.

Test Plan:
- Single write: req0 with addr 7'h42, wdata 8'hAA.
  - req_ready[0] 1 cycle; m_start 1 cycle later with m_addr=42, m_wdata=AA.
  - After m_done: rsp_valid[0] with rsp_timeout=0.
- Read: req2 read from 7'h42, master model returns 8'h3C.
  - rsp_valid[2] and rsp_rdata=3C.
- Contention: req0..3 all valid and held through completion.
  - Grant order 0,1,2,3,0.
  - owner matches each rsp_valid; no overlapping m_start.
- Timeout: master model never raises done, TIMEOUT_CYC=64.
  - m_abort high exactly 2 cycles starting 64 cycles after m_start.
  - Then rsp_valid[owner] with rsp_timeout=1 and rdata=00.
- Reset mid-transaction: assert rst for 1 cycle during WAIT_DONE.
  - All outputs 0 next cycle; no rsp_valid.
  - Next request granted to requester 0 first.
- Coincidence: m_done on the expiry cycle.
  - Normal response, m_abort never asserted.
